imm_extend_pipe: RTL and testbench

Pipelined, parametrised immediate-extension unit for the SimpleARM datapath. It replaces the combinational extender with a valid/ready-handshaked block. Beyond the existing modes, it adds:
- the ARM data-processing rotated imm8 with shifter carry-out;
- the halfword-transfer split imm8;
- an illegal-mode flag;
- a configurable result width and pipeline depth.

It sits between decode and the execute-stage operand mux.

---
 rtl/imm_extend_pipe.sv | 116 +++++++++++
 tb/tb_imm_extend_pipe.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender with a valid/ready handshake on both sides.
// Stage 1 computes and registers the extended immediate; an optional stage 2 only holds it.
module imm_extend_pipe #(
    parameter int DATA_W = 32,
    parameter int PIPE   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [23:0]       Instr,
    input  logic [2:0]        ImmSrc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ExtImm,
    output logic              RotCarry,
    output logic              RotCarryValid,
    output logic              Illegal
);

    typedef struct packed {
        logic [DATA_W-1:0] ext;
        logic              carry;
        logic              carry_valid;
        logic              illegal;
    } result_t;

    generate
        if (!(DATA_W == 32 || DATA_W == 64)) begin : g_bad_width
            $error("imm_extend_pipe: DATA_W must be 32 or 64");
        end
        if (!(PIPE == 1 || PIPE == 2)) begin : g_bad_pipe
            $error("imm_extend_pipe: PIPE must be 1 or 2");
        end
    endgenerate

    result_t     calc;
    logic [4:0]  rot_amt;
    logic [63:0] rot_pair;
    logic [31:0] rot_val;

    // Rotation stays within the low 32 bits even for a 64-bit result.
    always_comb begin
        rot_amt  = {Instr[11:8], 1'b0};
        rot_pair = {24'b0, Instr[7:0], 24'b0, Instr[7:0]} >> rot_amt;
        rot_val  = rot_pair[31:0];
        calc     = '0;
        case (ImmSrc)
            3'b000: calc.ext = DATA_W'(Instr[7:0]);
            3'b001: calc.ext = DATA_W'(Instr[11:0]);
            3'b010: calc.ext = {{(DATA_W-26){Instr[23]}}, Instr, 2'b00};
            3'b011: begin
                calc.ext         = DATA_W'(rot_val);
                calc.carry       = rot_val[31];
                calc.carry_valid = |Instr[11:8];
            end
            3'b100: calc.ext = DATA_W'({Instr[11:8], Instr[3:0]});
            default: calc.illegal = 1'b1;
        endcase
    end

    logic    v1_reg;
    result_t d1_reg;
    logic    adv1;
    logic    load1;
    result_t out_res;

    assign in_ready = !v1_reg || adv1;
    assign load1    = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            v1_reg <= 1'b0;
            d1_reg <= '0;
        end else if (load1) begin
            v1_reg <= 1'b1;
            d1_reg <= calc;
        end else if (adv1) begin
            v1_reg <= 1'b0;
        end
    end

    generate
        if (PIPE == 2) begin : g_stage2
            logic    v2_reg;
            result_t d2_reg;

            // Stage 1 may move on when stage 2 is empty or draining this cycle.
            assign adv1      = v1_reg && (!v2_reg || out_ready);
            assign out_valid = v2_reg;
            assign out_res   = d2_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    v2_reg <= 1'b0;
                    d2_reg <= '0;
                end else if (adv1) begin
                    v2_reg <= 1'b1;
                    d2_reg <= d1_reg;
                end else if (out_ready) begin
                    v2_reg <= 1'b0;
                end
            end
        end else begin : g_stage1_only
            assign adv1      = v1_reg && out_ready;
            assign out_valid = v1_reg;
            assign out_res   = d1_reg;
        end
    endgenerate

    assign ExtImm        = out_res.ext;
    assign RotCarry      = out_res.carry;
    assign RotCarryValid = out_res.carry_valid;
    assign Illegal       = out_res.illegal;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: instance a is 32-bit/1-stage, instance b is 64-bit/2-stage.
// A queue-based reference model predicts handshakes, latency and results for both.
module tb_imm_extend_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;

    logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b1;
    logic [23:0] a_instr = '0;
    logic [2:0]  a_src = '0;
    logic [31:0] a_ext;
    logic        a_carry, a_cvalid, a_illegal;

    logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1;
    logic [23:0] b_instr = '0;
    logic [2:0]  b_src = '0;
    logic [63:0] b_ext;
    logic        b_carry, b_cvalid, b_illegal;

    imm_extend_pipe #(.DATA_W(32), .PIPE(1)) u_dut_a (
        .clk(clk), .reset(reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .Instr(a_instr), .ImmSrc(a_src),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .ExtImm(a_ext), .RotCarry(a_carry), .RotCarryValid(a_cvalid), .Illegal(a_illegal)
    );

    imm_extend_pipe #(.DATA_W(64), .PIPE(2)) u_dut_b (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .Instr(b_instr), .ImmSrc(b_src),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .ExtImm(b_ext), .RotCarry(b_carry), .RotCarryValid(b_cvalid), .Illegal(b_illegal)
    );

    typedef struct {
        logic [63:0] ext;
        logic        carry;
        logic        cvalid;
        logic        illegal;
        int          acc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   cyc = 0;
    int   passed = 0;
    int   failed = 0;
    int   total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: rotation done one bit at a time, branch offset via signed arithmetic.
    function automatic exp_t model(input logic [23:0] instr, input logic [2:0] src,
                                   input int dw, input int acc);
        exp_t        e;
        logic [31:0] v;
        longint      s;
        e.ext = '0; e.carry = 1'b0; e.cvalid = 1'b0; e.illegal = 1'b0; e.acc = acc;
        case (src)
            3'd0: e.ext = 64'(instr[7:0]);
            3'd1: e.ext = 64'(instr[11:0]);
            3'd2: begin
                s = 0;
                s[25:0] = {instr, 2'b00};
                if (s >= 64'sd33554432) s = s - 64'sd67108864;
                e.ext = s;
            end
            3'd3: begin
                v = 32'(instr[7:0]);
                for (int i = 0; i < 2 * int'(instr[11:8]); i++) v = {v[0], v[31:1]};
                e.ext    = 64'(v);
                e.carry  = v[31];
                e.cvalid = (instr[11:8] != 4'd0);
            end
            3'd4: e.ext = 64'(instr[11:8]) * 64'd16 + 64'(instr[3:0]);
            default: e.illegal = 1'b1;
        endcase
        if (dw == 32) e.ext = e.ext & 64'hFFFF_FFFF;
        return e;
    endfunction

    // One clock: drive at the falling edge, then check both instances against the model.
    task automatic cycle(input bit va, input logic [23:0] ia, input logic [2:0] sa, input bit ra,
                         input bit vb, input logic [23:0] ib, input logic [2:0] sb, input bit rb);
        @(negedge clk);
        a_in_valid = va; a_instr = ia; a_src = sa; a_out_ready = ra;
        b_in_valid = vb; b_instr = ib; b_src = sb; b_out_ready = rb;
        #1;
        check("a_in_ready", 64'(a_in_ready), 64'((qa.size() < 1) || ra));
        check("a_out_valid", 64'(a_out_valid), 64'(qa.size() > 0 && cyc >= qa[0].acc + 1));
        if (a_out_valid && qa.size() > 0) begin
            check("a_ext", {32'b0, a_ext}, qa[0].ext);
            check("a_carry", 64'(a_carry), 64'(qa[0].carry));
            check("a_cvalid", 64'(a_cvalid), 64'(qa[0].cvalid));
            check("a_illegal", 64'(a_illegal), 64'(qa[0].illegal));
            if (ra) begin
                $display("[%0d] a out ext=%h carry=%b cvalid=%b illegal=%b",
                         cyc, a_ext, a_carry, a_cvalid, a_illegal);
                void'(qa.pop_front());
            end
        end
        if (va && a_in_ready) qa.push_back(model(ia, sa, 32, cyc));

        check("b_in_ready", 64'(b_in_ready), 64'((qb.size() < 2) || rb));
        check("b_out_valid", 64'(b_out_valid), 64'(qb.size() > 0 && cyc >= qb[0].acc + 2));
        if (b_out_valid && qb.size() > 0) begin
            check("b_ext", b_ext, qb[0].ext);
            check("b_carry", 64'(b_carry), 64'(qb[0].carry));
            check("b_cvalid", 64'(b_cvalid), 64'(qb[0].cvalid));
            check("b_illegal", 64'(b_illegal), 64'(qb[0].illegal));
            if (rb) begin
                $display("[%0d] b out ext=%h carry=%b cvalid=%b illegal=%b",
                         cyc, b_ext, b_carry, b_cvalid, b_illegal);
                void'(qb.pop_front());
            end
        end
        if (vb && b_in_ready) qb.push_back(model(ib, sb, 64, cyc));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0, '0, '0, 1'b1);
    endtask

    // Reset for one cycle while offering inputs that must not be accepted.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        a_in_valid = 1'b1; a_instr = 24'h0000AB; a_src = 3'd0; a_out_ready = 1'b0;
        b_in_valid = 1'b1; b_instr = 24'h0000CD; b_src = 3'd0; b_out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        a_in_valid = 1'b0; b_in_valid = 1'b0;
        qa.delete(); qb.delete();
        #1;
        check("rst_a_out_valid", 64'(a_out_valid), 64'd0);
        check("rst_a_ext", {32'b0, a_ext}, 64'd0);
        check("rst_a_carry", 64'(a_carry), 64'd0);
        check("rst_a_cvalid", 64'(a_cvalid), 64'd0);
        check("rst_a_illegal", 64'(a_illegal), 64'd0);
        check("rst_a_in_ready", 64'(a_in_ready), 64'd1);
        check("rst_b_out_valid", 64'(b_out_valid), 64'd0);
        check("rst_b_ext", b_ext, 64'd0);
        check("rst_b_carry", 64'(b_carry), 64'd0);
        check("rst_b_cvalid", 64'(b_cvalid), 64'd0);
        check("rst_b_illegal", 64'(b_illegal), 64'd0);
        check("rst_b_in_ready", 64'(b_in_ready), 64'd1);
    endtask

    logic [26:0] dir_a [6];
    logic [26:0] dir_b [3];
    int          seen, sent, first_acc, first_out, last_out, n_out;
    logic [23:0] ri;

    initial begin
        dir_a = '{{3'd3, 24'h0004FF}, {3'd3, 24'h0000FF}, {3'd4, 24'h000A05},
                  {3'd6, 24'h123456}, {3'd1, 24'hABCDEF}, {3'd2, 24'hFFFFFE}};
        dir_b = '{{3'd2, 24'hFFFFFE}, {3'd2, 24'h000003}, {3'd3, 24'h000F81}};

        do_reset();

        // Directed modes back to back on both instances.
        for (int i = 0; i < 6; i++) begin
            logic [26:0] ea;
            logic [26:0] eb;
            ea = dir_a[i];
            eb = dir_b[i % 3];
            cycle(1'b1, ea[23:0], ea[26:24], 1'b1, i < 3, eb[23:0], eb[26:24], 1'b1);
        end
        idle(4);
        check("directed_drained", 64'(qa.size() + qb.size()), 64'd0);

        // Backpressure on b: five imm8 values, first output stalled three cycles.
        seen = 0; sent = 0;
        for (int k = 0; k < 40 && (sent < 5 || qb.size() > 0); k++) begin
            cycle(1'b0, '0, '0, 1'b1, sent < 5, 24'(sent + 1), 3'd0, seen >= 3);
            if (b_out_valid) seen++;
            if (sent < 5 && b_in_ready) sent++;
        end
        check("bp_sent", 64'(sent), 64'd5);
        check("bp_drained", 64'(qb.size()), 64'd0);

        // Throughput on b: eight back-to-back accepts, results one per cycle.
        first_acc = -1; first_out = -1; last_out = -1; n_out = 0;
        for (int k = 0; k < 14; k++) begin
            ri = 24'($urandom);
            cycle(1'b0, '0, '0, 1'b1, k < 8, ri, 3'($urandom_range(0, 4)), 1'b1);
            if (k == 0 && b_in_ready) first_acc = cyc;
            if (b_out_valid) begin
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                n_out++;
            end
        end
        check("tp_first_latency", 64'(first_out - first_acc), 64'd2);
        check("tp_count", 64'(n_out), 64'd8);
        check("tp_span", 64'(last_out - first_out), 64'd7);

        // Random traffic with random backpressure on both instances.
        for (int k = 0; k < 400; k++) begin
            cycle(1'($urandom), 24'($urandom), 3'($urandom), 1'($urandom_range(0, 3) != 0),
                  1'($urandom), 24'($urandom), 3'($urandom), 1'($urandom_range(0, 3) != 0));
        end
        idle(6);
        check("random_drained", 64'(qa.size() + qb.size()), 64'd0);

        // Reset with results in flight: only post-reset inputs may appear.
        cycle(1'b1, 24'h000011, 3'd0, 1'b0, 1'b1, 24'h000022, 3'd0, 1'b0);
        cycle(1'b0, '0, '0, 1'b0, 1'b1, 24'h000033, 3'd0, 1'b0);
        check("inflight_b", 64'(qb.size()), 64'd2);
        do_reset();
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 24'(k + 8'h40), 3'd0, 1'b1, 1'b1, 24'(k + 8'h50), 3'd0, 1'b1);
        end
        idle(4);
        check("post_reset_drained", 64'(qa.size() + qb.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
